// File: rtl/acc_job_driver.sv
// Host-side start/done initiator: takes one job at a time, pulses start, waits
// for done or a bounded timeout, and returns the result on a valid/ready stream.
module acc_job_driver #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              job_valid_i,
  output logic              job_ready_o,
  input  logic [DATA_W-1:0] job_data_i,
  output logic              acc_start_o,
  output logic [DATA_W-1:0] acc_data_o,
  input  logic              acc_done_i,
  input  logic [DATA_W-1:0] acc_data_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DATA_W-1:0] res_data_o,
  output logic              res_err_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  job_cnt_o,
  output logic [CNT_W-1:0]  tmo_cnt_o
);

  localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             state_r;
  logic [TMR_W-1:0]   timer_r;
  logic               acc_start_r;
  logic [DATA_W-1:0]  acc_data_r;
  logic               res_valid_r;
  logic [DATA_W-1:0]  res_data_r;
  logic               res_err_r;
  logic               busy_r;
  logic [CNT_W-1:0]   job_cnt_r;
  logic [CNT_W-1:0]   tmo_cnt_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Ready is gated by reset so every output reads 0 while reset is asserted.
  assign job_ready_o = (state_r == S_IDLE) && arst_n_i;
  assign acc_start_o = acc_start_r;
  assign acc_data_o  = acc_data_r;
  assign res_valid_o = res_valid_r;
  assign res_data_o  = res_data_r;
  assign res_err_o   = res_err_r;
  assign busy_o      = busy_r;
  assign job_cnt_o   = job_cnt_r;
  assign tmo_cnt_o   = tmo_cnt_r;

  // Job sequencing FSM with all outputs registered alongside the state.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_r     <= S_IDLE;
      timer_r     <= '0;
      acc_start_r <= 1'b0;
      acc_data_r  <= '0;
      res_valid_r <= 1'b0;
      res_data_r  <= '0;
      res_err_r   <= 1'b0;
      busy_r      <= 1'b0;
      job_cnt_r   <= '0;
      tmo_cnt_r   <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (job_valid_i) begin
            acc_data_r  <= job_data_i;
            acc_start_r <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Done is deliberately not looked at here: a level left over from
          // the previous job must not complete this one.
          acc_start_r <= 1'b0;
          timer_r     <= '0;
          state_r     <= S_WAIT;
        end
        S_WAIT: begin
          if (acc_done_i) begin
            res_data_r  <= acc_data_i;
            res_err_r   <= 1'b0;
            res_valid_r <= 1'b1;
            state_r     <= S_RESP;
          end else if (timer_r == TMR_LAST) begin
            res_data_r  <= '0;
            res_err_r   <= 1'b1;
            res_valid_r <= 1'b1;
            tmo_cnt_r   <= sat_inc(tmo_cnt_r);
            state_r     <= S_RESP;
          end else begin
            timer_r <= timer_r + TMR_W'(1);
          end
        end
        S_RESP: begin
          if (res_ready_i) begin
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            job_cnt_r   <= sat_inc(job_cnt_r);
            state_r     <= S_IDLE;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          acc_start_r <= 1'b0;
          res_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_job_driver.sv
// Directed bench for acc_job_driver; the accelerator is driven by hand with
// precomputed byte-sum results.
module tb_acc_job_driver;

  localparam int DATA_W = 32;
  localparam int TMO    = 8;
  localparam int CNT_W  = 16;

  logic              clk_i = 1'b0;
  logic              arst_n_i;
  logic              job_valid_i;
  logic              job_ready_o;
  logic [DATA_W-1:0] job_data_i;
  logic              acc_start_o;
  logic [DATA_W-1:0] acc_data_o;
  logic              acc_done_i;
  logic [DATA_W-1:0] acc_data_i;
  logic              res_valid_o;
  logic              res_ready_i;
  logic [DATA_W-1:0] res_data_o;
  logic              res_err_o;
  logic              busy_o;
  logic [CNT_W-1:0]  job_cnt_o;
  logic [CNT_W-1:0]  tmo_cnt_o;

  int n_cmp = 0;
  int n_err = 0;
  int start_cnt = 0;
  int s0;

  acc_job_driver #(.DATA_W(DATA_W), .TIMEOUT_CYC(TMO), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_data_i(job_data_i),
    .acc_start_o(acc_start_o), .acc_data_o(acc_data_o),
    .acc_done_i(acc_done_i), .acc_data_i(acc_data_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_err_o(res_err_o),
    .busy_o(busy_o), .job_cnt_o(job_cnt_o), .tmo_cnt_o(tmo_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Count clock cycles during which the start pulse is high.
  always @(posedge clk_i) begin
    if (acc_start_o === 1'b1) start_cnt <= start_cnt + 1;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 64'(job_ready_o), 64'd0);
    chk({tag, "_start"}, 64'(acc_start_o), 64'd0);
    chk({tag, "_accd"},  64'(acc_data_o),  64'd0);
    chk({tag, "_rval"},  64'(res_valid_o), 64'd0);
    chk({tag, "_rdat"},  64'(res_data_o),  64'd0);
    chk({tag, "_rerr"},  64'(res_err_o),   64'd0);
    chk({tag, "_busy"},  64'(busy_o),      64'd0);
    chk({tag, "_jcnt"},  64'(job_cnt_o),   64'd0);
    chk({tag, "_tcnt"},  64'(tmo_cnt_o),   64'd0);
  endtask

  initial begin
    arst_n_i = 1'b0; job_valid_i = 1'b0; job_data_i = 32'd0;
    acc_done_i = 1'b0; acc_data_i = 32'd0; res_ready_i = 1'b0;
    tick(); tick();
    chk_all_zero("rst");
    arst_n_i = 1'b1;
    #1;
    chk("rst_rel_ready", 64'(job_ready_o), 64'd1);

    // 1: single job, done on third WAIT cycle
    s0 = start_cnt;
    job_valid_i = 1'b1; job_data_i = 32'h04030201;
    tick();
    job_valid_i = 1'b0;
    chk("t1_start", 64'(acc_start_o), 64'd1);
    chk("t1_accd", 64'(acc_data_o), 64'h04030201);
    chk("t1_ready_lo", 64'(job_ready_o), 64'd0);
    chk("t1_busy", 64'(busy_o), 64'd1);
    tick();
    chk("t1_start_fall", 64'(acc_start_o), 64'd0);
    tick();
    chk("t1_rval_w1", 64'(res_valid_o), 64'd0);
    tick();
    chk("t1_rval_w2", 64'(res_valid_o), 64'd0);
    acc_done_i = 1'b1; acc_data_i = 32'h0000000A;
    tick();
    acc_done_i = 1'b0;
    chk("t1_rval", 64'(res_valid_o), 64'd1);
    chk("t1_rdat", 64'(res_data_o), 64'h0A);
    chk("t1_rerr", 64'(res_err_o), 64'd0);
    chk("t1_jcnt_pre", 64'(job_cnt_o), 64'd0);
    chk("t1_one_start", 64'(start_cnt - s0), 64'd1);
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
    chk("t1_rval_done", 64'(res_valid_o), 64'd0);
    chk("t1_jcnt", 64'(job_cnt_o), 64'd1);
    chk("t1_ready_back", 64'(job_ready_o), 64'd1);

    // 2: back-to-back jobs, second waits on the stream
    res_ready_i = 1'b1;
    job_valid_i = 1'b1; job_data_i = 32'hFFFFFFFF;
    tick();
    job_data_i = 32'h4B196432;
    chk("t2_accd_a", 64'(acc_data_o), 64'hFFFFFFFF);
    chk("t2_ready_a0", 64'(job_ready_o), 64'd0);
    acc_done_i = 1'b1; acc_data_i = 32'h000003FC;
    tick();
    chk("t2_ready_a1", 64'(job_ready_o), 64'd0);
    tick();
    acc_done_i = 1'b0;
    chk("t2_rval_a", 64'(res_valid_o), 64'd1);
    chk("t2_rdat_a", 64'(res_data_o), 64'h3FC);
    chk("t2_ready_a2", 64'(job_ready_o), 64'd0);
    tick();
    chk("t2_jcnt_a", 64'(job_cnt_o), 64'd2);
    chk("t2_ready_idle", 64'(job_ready_o), 64'd1);
    tick();
    job_valid_i = 1'b0;
    chk("t2_accd_b", 64'(acc_data_o), 64'h4B196432);
    chk("t2_start_b", 64'(acc_start_o), 64'd1);
    acc_done_i = 1'b1; acc_data_i = 32'h000000FA;
    tick(); tick();
    acc_done_i = 1'b0;
    chk("t2_rval_b", 64'(res_valid_o), 64'd1);
    chk("t2_rdat_b", 64'(res_data_o), 64'hFA);
    tick();
    res_ready_i = 1'b0;
    chk("t2_jcnt_b", 64'(job_cnt_o), 64'd3);
    chk("t2_rval_off", 64'(res_valid_o), 64'd0);

    // 3: timeout, then a normal job
    job_valid_i = 1'b1; job_data_i = 32'h12345678;
    tick();
    job_valid_i = 1'b0;
    tick();
    repeat (TMO - 1) tick();
    chk("t3_rval_early", 64'(res_valid_o), 64'd0);
    tick();
    chk("t3_rval", 64'(res_valid_o), 64'd1);
    chk("t3_rdat", 64'(res_data_o), 64'd0);
    chk("t3_rerr", 64'(res_err_o), 64'd1);
    chk("t3_tcnt", 64'(tmo_cnt_o), 64'd1);
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
    chk("t3_jcnt", 64'(job_cnt_o), 64'd4);
    job_valid_i = 1'b1; job_data_i = 32'h04030201;
    tick();
    job_valid_i = 1'b0;
    acc_done_i = 1'b1; acc_data_i = 32'h0000000A;
    tick(); tick();
    acc_done_i = 1'b0;
    chk("t3_rdat_ok", 64'(res_data_o), 64'h0A);
    chk("t3_rerr_ok", 64'(res_err_o), 64'd0);
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
    chk("t3_jcnt2", 64'(job_cnt_o), 64'd5);
    chk("t3_tcnt2", 64'(tmo_cnt_o), 64'd1);

    // 4: done on the last timer cycle wins over timeout
    job_valid_i = 1'b1; job_data_i = 32'h00000055;
    tick();
    job_valid_i = 1'b0;
    tick();
    repeat (TMO - 1) tick();
    chk("t4_rval_early", 64'(res_valid_o), 64'd0);
    acc_done_i = 1'b1; acc_data_i = 32'h00000055;
    tick();
    acc_done_i = 1'b0;
    chk("t4_rval", 64'(res_valid_o), 64'd1);
    chk("t4_rdat", 64'(res_data_o), 64'h55);
    chk("t4_rerr", 64'(res_err_o), 64'd0);
    chk("t4_tcnt", 64'(tmo_cnt_o), 64'd1);
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
    chk("t4_jcnt", 64'(job_cnt_o), 64'd6);

    // 5: consumer stalls in RESP for 5 cycles
    job_valid_i = 1'b1; job_data_i = 32'h0A0B0C0D;
    tick();
    job_valid_i = 1'b0;
    acc_done_i = 1'b1; acc_data_i = 32'h0000002E;
    tick(); tick();
    acc_done_i = 1'b0;
    s0 = start_cnt;
    for (int i = 0; i < 5; i++) begin
      chk("t5_rval", 64'(res_valid_o), 64'd1);
      chk("t5_rdat", 64'(res_data_o), 64'h2E);
      chk("t5_accd", 64'(acc_data_o), 64'h0A0B0C0D);
      chk("t5_ready", 64'(job_ready_o), 64'd0);
      chk("t5_jcnt_hold", 64'(job_cnt_o), 64'd6);
      tick();
    end
    chk("t5_no_restart", 64'(start_cnt - s0), 64'd0);
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
    chk("t5_jcnt", 64'(job_cnt_o), 64'd7);

    // 6: async reset mid-WAIT, stale done held across the next ISSUE
    job_valid_i = 1'b1; job_data_i = 32'h01010101;
    tick();
    job_valid_i = 1'b0;
    tick(); tick();
    #2;
    arst_n_i = 1'b0;
    #1;
    chk_all_zero("t6_rst");
    acc_done_i = 1'b1; acc_data_i = 32'h00000099;
    tick();
    chk("t6_no_result", 64'(res_valid_o), 64'd0);
    arst_n_i = 1'b1;
    job_valid_i = 1'b1; job_data_i = 32'h01010101;
    tick();
    job_valid_i = 1'b0;
    chk("t6_start", 64'(acc_start_o), 64'd1);
    chk("t6_accd", 64'(acc_data_o), 64'h01010101);
    acc_data_i = 32'h00000004;
    tick();
    chk("t6_issue_ignores_done", 64'(res_valid_o), 64'd0);
    tick();
    acc_done_i = 1'b0;
    chk("t6_rval", 64'(res_valid_o), 64'd1);
    chk("t6_rdat", 64'(res_data_o), 64'h04);
    chk("t6_rerr", 64'(res_err_o), 64'd0);
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
    chk("t6_jcnt", 64'(job_cnt_o), 64'd1);
    chk("t6_tcnt", 64'(tmo_cnt_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
